// File: rtl/core_inst_seq.sv
// core_inst_seq -- instruction sequencer for the single-core datapath.
//
// On an accepted start it runs one complete tile and emits a registered
// 17-bit instruction word each cycle:
//   Q write (n rows) -> K write (col rows) -> kernel load (col rows)
//   -> settle gap (gap_cyc) -> execute (n rows) -> wait for ofifo_valid
//   -> drain output FIFO into psum memory (n rows) -> done pulse.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   start        one-cycle start pulse, accepted only in IDLE
//   abort        synchronous abort, highest priority
//   len[3:0]     Q rows this tile minus one (latched on start)
//   ofifo_valid  output FIFO has a readable row
//   inst[16:0]   instruction word to the core
//   mem_req      host must drive mem_in this cycle (Q/K write)
//   busy         high whenever not IDLE
//   done         one-cycle pulse at tile completion
//   err          sticky WAIT timeout flag, cleared by next accepted start
module core_inst_seq #(
  parameter int unsigned col     = 8,
  parameter int unsigned gap_cyc = 2,
  parameter int unsigned timeout = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [3:0]  len,
  input  logic        ofifo_valid,
  output logic [16:0] inst,
  output logic        mem_req,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_QWR,
    S_KWR,
    S_KLOAD,
    S_GAP,
    S_EXEC,
    S_WAIT,
    S_MOVE,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [4:0]  n_q, n_d;
  logic        err_q, err_d;
  logic [16:0] inst_q, inst_d;
  logic        mem_req_q, mem_req_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // MOVE-phase decisions handed from the next-state logic to the output logic
  logic        mv_rd;
  logic        mv_wr;
  logic [3:0]  mv_add;
  logic [4:0]  mv_nxt;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 5'd1;
    wcnt_d  = wcnt_q;
    n_d     = n_q;
    err_d   = err_q;
    mv_rd   = 1'b0;
    mv_wr   = 1'b0;
    mv_add  = '0;
    mv_nxt  = '0;

    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (start) begin
            state_d = S_QWR;
            n_d     = {1'b0, len} + 5'd1;
            err_d   = 1'b0;
          end
        end
        S_QWR: begin
          if (cnt_q == n_q - 5'd1) begin
            state_d = S_KWR;
            cnt_d   = '0;
          end
        end
        S_KWR: begin
          if (cnt_q == 5'(col - 1)) begin
            state_d = S_KLOAD;
            cnt_d   = '0;
          end
        end
        S_KLOAD: begin
          if (cnt_q == 5'(col - 1)) begin
            state_d = S_GAP;
            cnt_d   = '0;
          end
        end
        S_GAP: begin
          if (cnt_q == 5'(gap_cyc - 1)) begin
            state_d = S_EXEC;
            cnt_d   = '0;
          end
        end
        S_EXEC: begin
          if (cnt_q == n_q - 5'd1) begin
            state_d = S_WAIT;
            cnt_d   = '0;
            wcnt_d  = '0;
          end
        end
        S_WAIT: begin
          cnt_d = '0;
          if (ofifo_valid) begin
            state_d = S_MOVE;
            mv_rd   = 1'b1;
          end else if (wcnt_q == 8'(timeout - 1)) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else begin
            wcnt_d = wcnt_q + 8'd1;
          end
        end
        S_MOVE: begin
          // cnt is the index of the row being read when ofifo_rd is high;
          // a row read this cycle is written to psum memory next cycle.
          mv_wr  = inst_q[16];
          mv_add = cnt_q[3:0];
          mv_nxt = inst_q[16] ? cnt_q + 5'd1 : cnt_q;
          mv_rd  = ofifo_valid && (mv_nxt < n_q);
          cnt_d  = mv_nxt;
          if (inst_q[0] && ({1'b0, inst_q[11:8]} == n_q - 5'd1)) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output word for the state being entered, so it is visible from that edge
  always_comb begin
    inst_d    = '0;
    mem_req_d = 1'b0;
    done_d    = 1'b0;
    busy_d    = (state_d != S_IDLE);
    unique case (state_d)
      S_QWR: begin
        inst_d[4]     = 1'b1;
        inst_d[15:12] = cnt_d[3:0];
        mem_req_d     = 1'b1;
      end
      S_KWR: begin
        inst_d[2]     = 1'b1;
        inst_d[15:12] = cnt_d[3:0];
        mem_req_d     = 1'b1;
      end
      S_KLOAD: begin
        inst_d[3]     = 1'b1;
        inst_d[6]     = 1'b1;
        inst_d[15:12] = cnt_d[3:0];
      end
      S_EXEC: begin
        inst_d[5]     = 1'b1;
        inst_d[7]     = 1'b1;
        inst_d[15:12] = cnt_d[3:0];
      end
      S_MOVE: begin
        inst_d[16] = mv_rd;
        inst_d[0]  = mv_wr;
        if (mv_wr) begin
          inst_d[11:8] = mv_add;
        end
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        inst_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wcnt_q    <= '0;
      n_q       <= '0;
      err_q     <= 1'b0;
      inst_q    <= '0;
      mem_req_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wcnt_q    <= wcnt_d;
      n_q       <= n_d;
      err_q     <= err_d;
      inst_q    <= inst_d;
      mem_req_q <= mem_req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign inst    = inst_q;
  assign mem_req = mem_req_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_core_inst_seq.sv
// Directed testbench for core_inst_seq with an expected-trace scoreboard.
module tb_core_inst_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [3:0]  len;
  logic        ofifo_valid;
  logic [16:0] inst;
  logic        mem_req;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  core_inst_seq #(.col(8), .gap_cyc(2), .timeout(255)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .len         (len),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .mem_req     (mem_req),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  typedef struct {
    logic [16:0] inst;
    logic        mem_req;
    logic        busy;
    logic        done;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  int   rowq[$];
  int   checks = 0;
  int   errors = 0;
  int   wr_seen;
  int   busy_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("onehot_mem", 32'($countones(inst[5:2]) <= 1), 32'd1);
  endtask

  function automatic void push_e(input logic [16:0] i, input logic mr, input logic b,
                                 input logic d, input logic e);
    exp_t x;
    x.inst = i; x.mem_req = mr; x.busy = b; x.done = d; x.err = e;
    sbq.push_back(x);
  endfunction

  // QWR, KWR, KLOAD, GAP, EXEC for n Q rows
  function automatic void build_front(input int n);
    for (int c = 0; c < n; c++) push_e(17'h00010 | (17'(c) << 12), 1'b1, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) push_e(17'h00004 | (17'(c) << 12), 1'b1, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) push_e(17'h00048 | (17'(c) << 12), 1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 2; c++) push_e(17'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < n; c++) push_e(17'h000A0 | (17'(c) << 12), 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction

  // WAIT (one cycle, valid held high), MOVE, DONE, back to IDLE
  function automatic void build_back(input int n);
    logic [16:0] w;
    push_e(17'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k <= n; k++) begin
      w = '0;
      if (k < n) w[16] = 1'b1;
      if (k > 0) w = w | (17'(k - 1) << 8) | 17'h1;
      push_e(w, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    push_e(17'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    push_e(17'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  // Pop one expectation per cycle. Optionally re-pulse start mid-tile
  // (with a different len) and on the DONE cycle; both must be ignored.
  task automatic run_trace(input int restart_idx, input bit start_at_done);
    exp_t e;
    int   idx = 0;
    while (sbq.size() > 0) begin
      tick();
      e = sbq.pop_front();
      chk("inst", 32'(inst), 32'(e.inst));
      chk("mem_req", 32'(mem_req), 32'(e.mem_req));
      chk("busy", 32'(busy), 32'(e.busy));
      chk("done", 32'(done), 32'(e.done));
      chk("err", 32'(err), 32'(e.err));
      if (inst[0]) wr_seen++;
      if (busy) busy_seen++;
      start = (idx == restart_idx) || (start_at_done && e.done);
      if (idx == restart_idx) len = 4'd7;
      idx++;
    end
    start = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_inst"}, 32'(inst), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int  reads;
    bit  got_done;
    bit  pv;

    reset = 1'b0; start = 1'b0; abort = 1'b0; len = '0; ofifo_valid = 1'b1;

    // Reset state
    #3;
    chk_idle("reset");
    chk("reset_err", 32'(err), 32'd0);
    #9 reset = 1'b1;
    tick();
    chk_idle("post_reset");

    // Basic tile len=3; start re-pulsed mid-tile and on DONE
    len = 4'd3; start = 1'b1; busy_seen = 0; wr_seen = 0;
    build_front(4); build_back(4);
    run_trace(10, 1'b1);
    chk("basic_tile_cycles", 32'(busy_seen), 32'd33);
    chk("basic_wr_count", 32'(wr_seen), 32'd4);
    tick();
    chk_idle("basic_after");

    // Max tile len=15
    len = 4'd15; start = 1'b1; wr_seen = 0;
    build_front(16); build_back(16);
    run_trace(-1, 1'b0);
    chk("max_wr_count", 32'(wr_seen), 32'd16);

    // Backpressure: valid low for 10 WAIT cycles, then toggling during MOVE
    len = 4'd3; ofifo_valid = 1'b0; start = 1'b1;
    for (int r = 0; r < 4; r++) rowq.push_back(r);
    build_front(4);
    for (int c = 0; c < 10; c++) push_e(17'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_trace(-1, 1'b0);
    reads = 0; got_done = 1'b0;
    for (int i = 0; i < 60 && !got_done; i++) begin
      ofifo_valid = (i % 2 == 0);
      pv = ofifo_valid;
      tick();
      if (!pv) chk("bp_stall_rd", 32'(inst[16]), 32'd0);
      if (inst[16]) reads++;
      if (inst[0]) begin
        chk("bp_extra_wr", 32'(rowq.size() > 0), 32'd1);
        if (rowq.size() > 0) chk("bp_wr_row", 32'(inst[11:8]), 32'(rowq.pop_front()));
      end
      if (done) got_done = 1'b1;
    end
    chk("bp_done_seen", 32'(got_done), 32'd1);
    chk("bp_reads", 32'(reads), 32'd4);
    chk("bp_rows_left", 32'(rowq.size()), 32'd0);
    tick();
    chk_idle("bp_after");

    // Timeout: valid held low through WAIT
    len = 4'd0; ofifo_valid = 1'b0; start = 1'b1;
    build_front(1);
    for (int c = 0; c < 255; c++) push_e(17'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    push_e(17'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_trace(-1, 1'b0);
    tick();
    chk("to_err_sticky", 32'(err), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("to_err_cleared", 32'(err), 32'd0);
    chk("to_restart_inst", 32'(inst), 32'h10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("to_abort");

    // Abort during KLOAD cnt=4, then a full len=1 tile
    ofifo_valid = 1'b1; len = 4'd2; start = 1'b1;
    for (int c = 0; c < 3; c++) push_e(17'h00010 | (17'(c) << 12), 1'b1, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) push_e(17'h00004 | (17'(c) << 12), 1'b1, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) push_e(17'h00048 | (17'(c) << 12), 1'b0, 1'b1, 1'b0, 1'b0);
    run_trace(-1, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("abort");
    chk("abort_err", 32'(err), 32'd0);
    len = 4'd1; start = 1'b1;
    build_front(2); build_back(2);
    run_trace(-1, 1'b0);

    // Async reset mid-EXEC
    len = 4'd3; start = 1'b1;
    for (int c = 0; c < 4; c++) push_e(17'h00010 | (17'(c) << 12), 1'b1, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) push_e(17'h00004 | (17'(c) << 12), 1'b1, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) push_e(17'h00048 | (17'(c) << 12), 1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 2; c++) push_e(17'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 2; c++) push_e(17'h000A0 | (17'(c) << 12), 1'b0, 1'b1, 1'b0, 1'b0);
    run_trace(-1, 1'b0);
    #3 reset = 1'b0;
    #1;
    chk_idle("arst_immediate");
    start = 1'b1;
    tick();
    chk_idle("arst_start_in_reset");
    #3 reset = 1'b1;
    start = 1'b0;
    tick();
    chk_idle("arst_released");
    len = 4'd0; start = 1'b1;
    build_front(1); build_back(1);
    run_trace(-1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_inst_seq.md
Name: core_inst_seq

Overview:
- Instruction sequencer that generates the 17-bit `inst` word consumed by the single-core datapath (Q/K SRAMs, MAC array, output FIFO, psum SRAM).
- Replaces testbench-driven instruction streams. On `start`, runs one complete tile:
  - Q write, then K write.
  - Kernel load into the MAC array.
  - Execute.
  - Output FIFO drain into psum memory.
- Handshakes with the host for `mem_in` data and with the output FIFO valid flag.

Parameters:
- col, 8, MAC array columns; number of K rows written and loaded.
- gap_cyc, 2, idle cycles between kernel load and execute (array pipeline settle).
- timeout, 255, max cycles waiting for ofifo_valid before error.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; accepted only in IDLE.
- abort  input  1  synchronous abort; takes priority over start and all states.
- len  input  4  Q rows this tile = len+1 (1..16); latched on accepted start.
- ofifo_valid  input  1  output FIFO has a full row readable.
- inst  output  17  registered instruction word to the core.
- mem_req  output  1  host must drive mem_in this cycle (a Q/K write is issued).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at tile completion.
- err  output  1  sticky timeout flag; cleared by next accepted start.

Behaviour:
- inst field map:
  - [16] ofifo_rd
  - [15:12] qkmem_add
  - [11:8] pmem_add
  - [7] execute
  - [6] kernel load / K-mux select
  - [5] qmem_rd, [4] qmem_wr
  - [3] kmem_rd, [2] kmem_wr
  - [1] pmem_rd, [0] pmem_wr
  - Every field not listed as driven in a state is 0.
- Reset (reset=0, async): state=IDLE, inst=0, mem_req=0, busy=0, done=0, err=0, counters=0.
- All outputs are registered. A state entered at edge t has its inst value visible from edge t.
- n = len+1, latched on accepted start. cnt is a 5-bit phase counter, cleared on every state change.
- IDLE: inst=0. start=1 -> QWR; err cleared; n latched.
- QWR, n cycles: inst[4]=1, qkmem_add=cnt, mem_req=1. After cnt=n-1 -> KWR.
- KWR, col cycles: inst[2]=1, qkmem_add=cnt, mem_req=1 -> KLOAD.
- KLOAD, col cycles: inst[3]=1, inst[6]=1, qkmem_add=cnt -> GAP.
- GAP, gap_cyc cycles: inst=0 -> EXEC.
- EXEC, n cycles: inst[5]=1, inst[7]=1, qkmem_add=cnt -> WAIT.
- WAIT: inst=0; counts cycles.
  - ofifo_valid=1 -> MOVE.
  - Count reaches timeout with no valid -> err=1, go to IDLE, no done pulse.
- MOVE:
  - Row k read: ofifo_rd=1 in cycle c(k); pmem_wr=1 with pmem_add=k in cycle c(k)+1 (one-cycle write pipeline).
  - ofifo_valid=0 stalls the read counter (ofifo_rd=0); a pending pmem_wr still completes.
  - ofifo_rd and pmem_wr may be high in the same cycle (pipelined).
  - After the write of row n-1 -> DONE.
- DONE: one cycle, done=1, inst=0 -> IDLE.
- abort=1 in any state: next edge -> IDLE with inst=0. No done pulse; err unchanged; an in-flight pmem_wr is dropped.
- start while busy: ignored.
- A start coincident with the DONE cycle is ignored; start is accepted only in IDLE.
- len=15 gives n=16; addresses cover 0..15 with no wrap and no overflow.
- At most one of qmem_wr/qmem_rd/kmem_wr/kmem_rd is high in any cycle. Verification asserts this invariant.

Test Plan:
- Basic tile, len=3, col=8, ofifo_valid tied 1:
  - 4 QWR cycles at addr 0..3 with mem_req=1.
  - 8 KWR cycles, then 8 KLOAD cycles with inst[6]=1.
  - 2 idle cycles, then 4 EXEC cycles with inst=0x00A0|addr<<12.
  - MOVE writes pmem_add 0..3, then done pulses once.
  - Total tile length = 4+8+8+2+4+1+5+1 cycles.
- Max tile, len=15: qkmem_add and pmem_add reach 15 with no wrap; exactly 16 pmem_wr pulses.
- Backpressure: ofifo_valid=0 for 10 cycles after EXEC, then toggled 1/0 during MOVE:
  - Each stalled cycle has ofifo_rd=0.
  - pmem writes stay in order 0..n-1, with no duplicates or gaps.
- Timeout: ofifo_valid held 0 -> err=1 after 255 WAIT cycles, back to IDLE, done=0.
  - Next start clears err.
- Abort during KLOAD (cnt=4) -> inst=0 at the next edge, busy=0.
  - A following start with len=1 runs a correct full tile.
- Async reset asserted mid-EXEC, between clock edges -> inst=0, busy=0 immediately.
  - After release, start is ignored until sampled in IDLE.
